// File: rtl/uart_tx_arb_pkg.sv
// ============================================================================
//  Module   : uart_tx_arb_pkg
//  Purpose  : Shared state encoding and counter widths for the UART TX
//             arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_tx_arb_pkg;

   // Arbiter FSM encoding: waiting for a requester, owner holds the grant,
   // byte presented to the UART
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN  = 2'd1,
      ST_SEND = 2'd2
   } state_e;

   // Idle-timeout counter is a fixed 8-bit counter
   localparam int IDLE_W = 8;

   // Byte counter must be able to hold LOCK_MAX itself
   function automatic int cnt_width(input int lock_max);
      return $clog2(lock_max + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_arb_rr_pick.sv
// ============================================================================
//  Module   : uart_tx_arb_rr_pick
//  Purpose  : Combinational requester picker. Default build is round-robin
//             starting at the pointer; with UART_ARB_PRIO_EN defined it is
//             fixed priority (lowest index wins) and the pointer is ignored.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_arb_rr_pick
   import uart_tx_arb_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
)(
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N_REQ-1:0] grant_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

`ifdef UART_ARB_PRIO_EN
   logic             w_unused_ptr;
   logic [IDX_W-1:0] w_cand;

   assign w_unused_ptr = ^ptr_i;

   // Fixed priority: scan from the top down so the lowest index wins
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      w_cand  = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         w_cand = IDX_W'(i);
         if (req_i[w_cand]) begin
            grant_o         = '0;
            grant_o[w_cand] = 1'b1;
            idx_o           = w_cand;
            valid_o         = 1'b1;
         end
      end
   end
`else
   logic [IDX_W:0]   w_sum;
   logic [IDX_W-1:0] w_cand;

   // Round-robin: first requester at or after the pointer, wrapping at N_REQ
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      w_sum   = '0;
      w_cand  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         w_sum = {1'b0, ptr_i} + (IDX_W + 1)'(i);
         if (w_sum >= (IDX_W + 1)'(N_REQ)) begin
            w_sum = w_sum - (IDX_W + 1)'(N_REQ);
         end
         w_cand = w_sum[IDX_W-1:0];
         if (!valid_o && req_i[w_cand]) begin
            grant_o[w_cand] = 1'b1;
            idx_o           = w_cand;
            valid_o         = 1'b1;
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: rtl/uart_tx_arb.sv
// ============================================================================
//  Module   : uart_tx_arb
//  Purpose  : Shares one UART TX byte interface between N_REQ byte-stream
//             requesters. A grant lasts for a whole message and ends on
//             LAST_I, after LOCK_MAX bytes, or after IDLE_TO idle cycles.
//             Build option UART_ARB_PRIO_EN selects fixed-priority picking
//             instead of round-robin.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_arb
   import uart_tx_arb_pkg::*;
#(
   parameter int N_REQ    = 2,
   parameter int LOCK_MAX = 64,
   parameter int IDLE_TO  = 255
)(
   input  logic               CLK_I,
   input  logic               RST_I,
   input  logic [N_REQ-1:0]   REQ_I,
   input  logic [8*N_REQ-1:0] DATA_I,
   input  logic [N_REQ-1:0]   LAST_I,
   output logic [N_REQ-1:0]   ACK_O,
   output logic [N_REQ-1:0]   GRANT_O,
   output logic [7:0]         TX_DATA_O,
   output logic               TX_VALID_O,
   input  logic               TX_READY_I,
   output logic               BUSY_O
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = cnt_width(LOCK_MAX);

   localparam logic [CNT_W-1:0]  c_lock_max  = CNT_W'(LOCK_MAX);
   localparam logic [IDLE_W-1:0] c_idle_last = IDLE_W'(IDLE_TO - 1);
   localparam logic [IDX_W-1:0]  c_last_idx  = IDX_W'(N_REQ - 1);

   state_e            state_q,    state_d;
   logic [N_REQ-1:0]  grant_q,    grant_d;
   logic [IDX_W-1:0]  owner_q,    owner_d;
   logic [IDX_W-1:0]  ptr_q,      ptr_d;
   logic [CNT_W-1:0]  cnt_q,      cnt_d;
   logic [IDLE_W-1:0] idle_q,     idle_d;
   logic [N_REQ-1:0]  ack_q,      ack_d;
   logic [7:0]        tx_data_q,  tx_data_d;
   logic              tx_valid_q, tx_valid_d;
   logic              last_q,     last_d;

   logic              w_release;
   logic [N_REQ-1:0]  w_pick_grant;
   logic [IDX_W-1:0]  w_pick_idx;
   logic              w_pick_valid;

   uart_tx_arb_rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req_i   (REQ_I),
      .ptr_i   (ptr_q),
      .grant_o (w_pick_grant),
      .idx_o   (w_pick_idx),
      .valid_o (w_pick_valid)
   );

   // Next-state logic: grant on request, move one byte per OWN->SEND pass,
   // release on LAST, byte limit or idle timeout
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      owner_d    = owner_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      idle_d     = idle_q;
      ack_d      = '0;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      last_d     = last_q;
      w_release  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (w_pick_valid) begin
               grant_d = w_pick_grant;
               owner_d = w_pick_idx;
               state_d = ST_OWN;
            end
         end
         ST_OWN: begin
            if (REQ_I[owner_q]) begin
               // grant_q is one-hot on the owner, so it doubles as the ACK mask
               ack_d      = grant_q;
               tx_data_d  = DATA_I[{owner_q, 3'b000} +: 8];
               last_d     = LAST_I[owner_q];
               cnt_d      = cnt_q + CNT_W'(1);
               tx_valid_d = 1'b1;
               state_d    = ST_SEND;
            end else if (idle_q == c_idle_last) begin
               w_release = 1'b1;
            end else begin
               idle_d = idle_q + IDLE_W'(1);
            end
         end
         ST_SEND: begin
            if (TX_READY_I) begin
               tx_valid_d = 1'b0;
               if (last_q || (cnt_q == c_lock_max)) begin
                  w_release = 1'b1;
               end else begin
                  idle_d  = '0;
                  state_d = ST_OWN;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (w_release) begin
         grant_d = '0;
         ptr_d   = (owner_q == c_last_idx) ? '0 : owner_q + IDX_W'(1);
         cnt_d   = '0;
         idle_d  = '0;
         state_d = ST_IDLE;
      end
   end

   // State register; reset also abandons any byte in flight
   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         owner_q    <= '0;
         ptr_q      <= '0;
         cnt_q      <= '0;
         idle_q     <= '0;
         ack_q      <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         last_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         owner_q    <= owner_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         idle_q     <= idle_d;
         ack_q      <= ack_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         last_q     <= last_d;
      end
   end

   assign ACK_O      = ack_q;
   assign GRANT_O    = grant_q;
   assign TX_DATA_O  = tx_data_q;
   assign TX_VALID_O = tx_valid_q;
   assign BUSY_O     = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
// ============================================================================
//  Module   : tb_uart_tx_arb
//  Purpose  : Self-checking bench for uart_tx_arb (N_REQ=2, LOCK_MAX=4).
//             Requester models feed byte queues; the expected UART byte
//             order, tagged with the owning grant, sits in a scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req;
   logic [15:0] data;
   logic [1:0]  last;
   logic [1:0]  ack;
   logic [1:0]  grant;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;

   int checks = 0;
   int errors = 0;

   logic [8:0]  rq0[$];
   logic [8:0]  rq1[$];
   logic [9:0]  exp_q[$];
   logic        ready_want;

   always #5 clk = ~clk;

   uart_tx_arb #(
      .N_REQ    (2),
      .LOCK_MAX (4),
      .IDLE_TO  (255)
   ) dut (
      .CLK_I      (clk),
      .RST_I      (rst_n),
      .REQ_I      (req),
      .DATA_I     (data),
      .LAST_I     (last),
      .ACK_O      (ack),
      .GRANT_O    (grant),
      .TX_DATA_O  (tx_data),
      .TX_VALID_O (tx_valid),
      .TX_READY_I (tx_ready),
      .BUSY_O     (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic push_req(input int k, input logic [7:0] b, input logic l);
      if (k == 0) rq0.push_back({l, b});
      else        rq1.push_back({l, b});
   endtask

   task automatic expect_tx(input int k, input logic [7:0] b);
      exp_q.push_back({2'(1 << k), b});
   endtask

   // One cycle: consume ACKs, drive requesters, then score any handshake
   // that will occur at the coming rising edge
   task automatic step();
      logic [9:0] e;
      @(negedge clk);
      if (ack != 2'b00) begin
         check("ack_onehot", $countones(ack), 1);
         check("ack_owner", ack & ~grant, 0);
         if (ack[0] && rq0.size() > 0) void'(rq0.pop_front());
         if (ack[1] && rq1.size() > 0) void'(rq1.pop_front());
      end
      req[0]     = (rq0.size() > 0);
      data[7:0]  = (rq0.size() > 0) ? rq0[0][7:0] : 8'h00;
      last[0]    = (rq0.size() > 0) ? rq0[0][8] : 1'b0;
      req[1]     = (rq1.size() > 0);
      data[15:8] = (rq1.size() > 0) ? rq1[0][7:0] : 8'h00;
      last[1]    = (rq1.size() > 0) ? rq1[0][8] : 1'b0;
      tx_ready   = ready_want;
      if (tx_valid && tx_ready) begin
         if (exp_q.size() == 0) begin
            check("tx_extra", exp_q.size(), 1);
         end else begin
            e = exp_q.pop_front();
            check("tx_byte", {grant, tx_data}, e);
         end
      end
   endtask

   task automatic drain(input int budget, input string tag);
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < budget) begin
         step();
         n++;
      end
      check(tag, (exp_q.size() != 0 || busy), 0);
   endtask

   initial begin
      int n;
      int own;
      rst_n      = 1'b0;
      req        = '0;
      data       = '0;
      last       = '0;
      tx_ready   = 1'b1;
      ready_want = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_outs", {ack, grant, tx_data, tx_valid, busy}, 0);
      rst_n = 1'b1;

      // Both requesters hold 3-byte messages from the start, pointer at 0
      push_req(0, 8'h10, 0); push_req(0, 8'h11, 0); push_req(0, 8'h12, 1);
      push_req(1, 8'h20, 0); push_req(1, 8'h21, 0); push_req(1, 8'h22, 1);
      expect_tx(0, 8'h10); expect_tx(0, 8'h11); expect_tx(0, 8'h12);
      expect_tx(1, 8'h20); expect_tx(1, 8'h21); expect_tx(1, 8'h22);
      drain(100, "both_ptr0");

      // Single requester sends "HI\n"
      push_req(0, 8'h48, 0); push_req(0, 8'h49, 0); push_req(0, 8'h0A, 1);
      expect_tx(0, 8'h48); expect_tx(0, 8'h49); expect_tx(0, 8'h0A);
      drain(100, "hi_msg");
      check("hi_idle", {grant, busy}, 0);

      // Both again, pointer now 1 after req0's release
      push_req(0, 8'h13, 0); push_req(0, 8'h14, 0); push_req(0, 8'h15, 1);
      push_req(1, 8'h23, 0); push_req(1, 8'h24, 0); push_req(1, 8'h25, 1);
`ifdef UART_ARB_PRIO_EN
      expect_tx(0, 8'h13); expect_tx(0, 8'h14); expect_tx(0, 8'h15);
      expect_tx(1, 8'h23); expect_tx(1, 8'h24); expect_tx(1, 8'h25);
`else
      expect_tx(1, 8'h23); expect_tx(1, 8'h24); expect_tx(1, 8'h25);
      expect_tx(0, 8'h13); expect_tx(0, 8'h14); expect_tx(0, 8'h15);
`endif
      drain(100, "both_ptr1");

      // Six bytes without LAST, byte limit 4, req1 waiting behind
      for (int i = 0; i < 6; i++) push_req(0, 8'h30 + 8'(i), 0);
      step(); step();
      push_req(1, 8'h40, 0); push_req(1, 8'h41, 0); push_req(1, 8'h42, 1);
      for (int i = 0; i < 4; i++) expect_tx(0, 8'h30 + 8'(i));
`ifdef UART_ARB_PRIO_EN
      expect_tx(0, 8'h34); expect_tx(0, 8'h35);
      expect_tx(1, 8'h40); expect_tx(1, 8'h41); expect_tx(1, 8'h42);
`else
      expect_tx(1, 8'h40); expect_tx(1, 8'h41); expect_tx(1, 8'h42);
      expect_tx(0, 8'h34); expect_tx(0, 8'h35);
`endif
      drain(1000, "lock_max");

      // Owner goes quiet after one byte; grant must persist 255 idle cycles
      push_req(0, 8'h50, 0);
      expect_tx(0, 8'h50);
      step(); step();
      push_req(1, 8'h60, 1);
      expect_tx(1, 8'h60);
      n = 0;
      while (exp_q.size() > 1 && n < 50) begin
         step();
         n++;
      end
      check("idle_first_byte", exp_q.size(), 1);
      own = 0;
      for (int i = 0; i < 400; i++) begin
         step();
         if (grant == 2'b01) own++;
         else break;
      end
      check("idle_hold_cycles", own, 255);
      drain(50, "idle_next");

      // UART stalls for 20 cycles while a byte is presented
      ready_want = 1'b0;
      push_req(0, 8'h70, 0); push_req(0, 8'h71, 1);
      expect_tx(0, 8'h70); expect_tx(0, 8'h71);
      n = 0;
      while (!tx_valid && n < 20) begin
         step();
         n++;
      end
      check("stall_valid", tx_valid, 1);
      for (int i = 0; i < 20; i++) begin
         step();
         check("stall_hold", {tx_valid, tx_data, ack}, {1'b1, 8'h70, 2'b00});
      end
      ready_want = 1'b1;
      drain(50, "stall_done");

      // Reset asserted while a byte is in flight
      ready_want = 1'b0;
      push_req(1, 8'h80, 1);
      n = 0;
      while (!tx_valid && n < 20) begin
         step();
         n++;
      end
      check("rst_mid_valid", tx_valid, 1);
      #2 rst_n = 1'b0;
      #1 check("rst_async", {ack, grant, tx_data, tx_valid, busy}, 0);
      rq0.delete();
      rq1.delete();
      exp_q.delete();
      ready_want = 1'b1;
      step(); step();
      rst_n = 1'b1;
      step(); step();
      check("post_rst_idle", {grant, busy, tx_valid}, 0);

      // Pointer restarts at 0 after reset
      push_req(0, 8'h90, 1);
      push_req(1, 8'hA0, 1);
      expect_tx(0, 8'h90);
      expect_tx(1, 8'hA0);
      drain(50, "post_rst_order");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
